// File: rtl/mac_pkg.sv
// mac_pkg: shared MAC widths and the result/entry types used by the MAC pipeline and its collector.
package mac_pkg;
    localparam int MAC_ACC_W  = 32;
    localparam int MAC_OPND_W = 8;
    typedef logic signed [MAC_ACC_W-1:0] mac_result_t;
    typedef struct packed {
        mac_result_t data;
        logic        last;
    } collector_entry_t;
endpackage

// File: rtl/mac_result_collector_if.sv
// mac_result_collector_if: result input stream, downstream valid/ready port and status/control of the collector.
interface mac_result_collector_if import mac_pkg::*; #(
    parameter int DATA_W = MAC_ACC_W,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic                     m_last;
    logic [CNT_W-1:0]         count;
    logic                     overflow;
    logic                     clr_ovf;
    modport master (
        output in_valid, in_data, m_ready, clr_ovf,
        input  m_valid, m_data, m_last, count, overflow
    );
    modport slave (
        input  in_valid, in_data, m_ready, clr_ovf,
        output m_valid, m_data, m_last, count, overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO over an arbitrary entry type; the caller must not push when full without popping.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       wdata_i,
    output T                       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    always_comb begin
        wr_d  = push_i ? wr_q + 1'b1 : wr_q;
        rd_d  = pop_i ? rd_q + 1'b1 : rd_q;
        cnt_d = (push_i && !pop_i) ? cnt_q + 1'b1 : (pop_i && !push_i) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !rst)
            mem_q[wr_q] <= wdata_i;
    end
    assign rdata_o = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector: buffers the unthrottled MAC result stream and replays it on valid/ready with frame tags.
// Optional COLLECTOR_SAT_EN: store (in_data >>> SHIFT) clamped to the signed operand range instead of in_data.
module mac_result_collector import mac_pkg::*; #(
    parameter int DATA_W    = MAC_ACC_W,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int SHIFT     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_result_collector_if.slave bus
);
    localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    typedef struct packed {
        logic signed [DATA_W-1:0] data;
        logic                     last;
    } entry_t;
    entry_t                   wentry, head;
    logic                     full, empty, push, pop, drop, last_pos;
    logic [PW-1:0]            pos_q, pos_d;
    logic                     ovf_q, ovf_d;
    logic signed [DATA_W-1:0] wdata;
    assign pop      = !empty && bus.m_ready;
    assign push     = bus.in_valid && (!full || pop);
    assign drop     = bus.in_valid && !push;
    assign last_pos = pos_q == PW'(FRAME_LEN - 1);
`ifdef COLLECTOR_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_HI = DATA_W'((1 << (MAC_OPND_W - 1)) - 1);
    localparam logic signed [DATA_W-1:0] SAT_LO = DATA_W'(-(1 << (MAC_OPND_W - 1)));
    logic signed [DATA_W-1:0] shifted;
    assign shifted = bus.in_data >>> SHIFT;
    assign wdata   = (shifted > SAT_HI) ? SAT_HI : (shifted < SAT_LO) ? SAT_LO : shifted;
`else
    logic [31:0] unused_shift;
    assign unused_shift = SHIFT;
    assign wdata        = bus.in_data;
`endif
    // Dropped results neither advance the frame position nor escape the sticky flag; set beats clear.
    always_comb begin
        pos_d  = push ? (last_pos ? '0 : pos_q + 1'b1) : pos_q;
        ovf_d  = drop ? 1'b1 : bus.clr_ovf ? 1'b0 : ovf_q;
        wentry = '{data: wdata, last: last_pos};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            ovf_q <= ovf_d;
        end
    end
    sync_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (bus.count)
    );
    assign bus.m_valid  = !empty;
    assign bus.m_data   = empty ? '0 : head.data;
    assign bus.m_last   = !empty && head.last;
    assign bus.overflow = ovf_q;
endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
Receive-side companion of mac_pipeline. It captures the fire-and-forget out_valid/y result stream, which has no backpressure, into a small FIFO. It presents the results downstream on a valid/ready interface, tagging frame boundaries. Overflow is detected and flagged, never silently hidden.

Parameters:
DATA_W, 32, width of incoming MAC result and m_data
DEPTH, 8, FIFO entries; power of two, >= 2
FRAME_LEN, 4, results per frame; m_last marks the last; >= 1
SHIFT, 0, arithmetic right shift used only when the optional feature is enabled

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  result strobe; connect to mac_pipeline out_valid
in_data  in  DATA_W  signed result; connect to mac_pipeline y
m_valid  out  1  head entry available
m_ready  in  1  downstream accepts head entry
m_data  out  DATA_W  signed head data
m_last  out  1  head entry is the last of a frame
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky; a result was dropped
clr_ovf  in  1  clears overflow

Behaviour:
- Reset (rst=1 at a rising edge): occupancy=0, read/write pointers=0, frame position=0, overflow=0. Outputs then read m_valid=0, m_data=0, m_last=0, count=0. Reset mid-stream discards all stored entries, and in_valid during reset is ignored.
- push = in_valid & (!full | pop). pop = m_valid & m_ready.
- Latency: a result accepted at edge N appears at the head after edge N if the FIFO was empty. m_valid is driven from registered state (not-empty) and never combinationally depends on in_valid.
- m_valid = (count != 0). m_data and m_last show the head entry. When empty, m_data=0 and m_last=0.
- m_data/m_last stay stable while m_valid=1 and m_ready=0.
- Full with simultaneous pop: pop and push both occur and count is unchanged. Write and read pointers wrap modulo DEPTH.
- Full without pop and in_valid=1: the result is dropped, overflow is set at that edge, and the frame position does not advance.
- Empty with simultaneous push: no pass-through. The entry becomes visible the next cycle.
- Frame tagging: the frame position counter advances only on accepted pushes. The stored last bit = (position == FRAME_LEN-1). Position then wraps to 0.
- overflow: a set event and clr_ovf in the same cycle leave overflow=1, because set has priority.
- count increments on push-only, decrements on pop-only, and is unchanged otherwise.
- m_ready while empty has no effect.

Optional Feature:
Macro COLLECTOR_SAT_EN.
- Defined: the stored value is (in_data >>> SHIFT) saturated to the signed 8-bit range [-128, 127], sign-extended to DATA_W. Conversion happens at write time, so the storage timing is unchanged.
- Undefined: in_data is stored unmodified and SHIFT is unused.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package mac_pkg: MAC_ACC_W=32 and MAC_OPND_W=8 constants, plus a typedef mac_result_t (signed logic [MAC_ACC_W-1:0]) and a typedef collector_entry_t (struct: data, last).
- One natural sub-module, sync_fifo. It is parameterized on entry type and depth, has push/pop/full/empty/count, and is reused elsewhere.
- Frame tagging, overflow and saturation stay in the top.

Test Plan:
- Basic: after reset, m_ready=1, FRAME_LEN=4; push 22, -9, 64 on consecutive cycles. Expect m_data 22, -9, 64 in order, each one cycle after its push, with m_last=0 on all three and overflow=0.
- Frame: push 8 values 1..8 with m_ready=1. Expect m_last=1 exactly on 4 and 8.
- Overflow: m_ready=0, push 10 values 0..9 into DEPTH=8. Expect count=8, overflow=1 after value 8, and draining yields 0..7 only. Then pulse clr_ovf and expect overflow=0.
- Full plus pop: fill 8 entries, then in one cycle set in_valid=1 (value 100) and m_ready=1. Expect count stays 8, overflow=0, and 100 is drained last.
- Reset mid-stream: with 3 entries stored, assert rst for one cycle. Expect m_valid=0, count=0, and a subsequent push of 5 emerges with m_last=0 (frame position restarted).
- COLLECTOR_SAT_EN with SHIFT=2: push 1000, -1000, 20. Expect m_data 127, -128, 5.
